async_fifo_rd_ctrl: RTL and testbench

//  Read-domain controller for the async FIFO. Consumes the write pointer (Gray) delivered by the
//  2-flop pointer synchronizer, tracks occupancy, sequences reads of the registered-output FIFO RAM,
//  and presents data on a valid/ready stream through a 2-entry output buffer. Publishes its own Gray

---
 rtl/async_fifo_pkg.sv | 24 ++
 rtl/rd_out_buf.sv | 50 +++++
 rtl/async_fifo_rd_ctrl.sv | 99 +++++++++
 tb/tb_async_fifo_rd_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Pointer helpers shared by the read- and write-side controllers of the async FIFO.
// Pointers carry one extra wrap bit above the RAM address (see ptr_w).
package async_fifo_pkg;

  localparam int PTR_MAX_W = 16;

  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_out_buf.sv
// Two-entry output FIFO between the registered RAM read port and the valid/ready stream.
// Push and pop may coincide; the head entry stays stable until it is popped.
module rd_out_buf
  import async_fifo_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        cnt
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_cnt;
  logic              w_push;
  logic              w_pop;

  // Guards keep the entry count consistent even if a caller misbehaves.
  assign w_pop  = pop && (r_cnt != 2'd0);
  assign w_push = push && ((r_cnt != 2'd2) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign dout = r_mem[r_rd_ptr];
  assign cnt  = r_cnt;

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: occupancy from the synced Gray write pointer,
// RAM read sequencing, 2-entry output buffer, and the Gray read pointer for the write side.
module async_fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 8,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   wptr_gray_sync,
  output logic [ADDR_W:0]   rptr_gray,
  output logic              ren,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata_mem,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              empty,
  output logic              almost_empty,
  output logic              err
);

  localparam int PTR_W = ptr_w(ADDR_W);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TOT_W = PTR_W + 2;

  logic [PTR_W-1:0]     r_rbin;
  logic [PTR_W-1:0]     r_rptr_gray;
  logic                 r_inflight;
  logic                 r_err;

  logic [PTR_MAX_W-1:0] w_wbin_ext;
  logic [PTR_MAX_W-1:0] w_rgray_ext;
  logic [PTR_W-1:0]     w_wbin;
  logic [PTR_W-1:0]     w_rd_count;
  logic [PTR_W-1:0]     w_rbin_nxt;
  logic [TOT_W-1:0]     w_total;
  logic [2:0]           w_occ;
  logic [1:0]           w_buf_cnt;
  logic                 w_pop;
  logic                 w_err_cond;
  logic                 w_ren;

  always_comb begin
    w_wbin_ext  = gray2bin(PTR_MAX_W'(wptr_gray_sync));
    w_wbin      = w_wbin_ext[PTR_W-1:0];
    w_rd_count  = w_wbin - r_rbin;
    w_err_cond  = w_rd_count > PTR_W'(DEPTH);
    w_pop       = m_valid & m_ready;
    // Slots committed to the buffer after this edge; pop frees one in the same cycle.
    w_occ       = {1'b0, w_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_ren       = (w_rd_count != '0) && !w_err_cond && (w_occ < 3'd2);
    w_rbin_nxt  = r_rbin + PTR_W'(1);
    w_rgray_ext = bin2gray(PTR_MAX_W'(w_rbin_nxt));
    w_total     = TOT_W'(w_rd_count) + TOT_W'(w_buf_cnt) + TOT_W'(r_inflight);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rbin      <= '0;
      r_rptr_gray <= '0;
      r_inflight  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_inflight <= w_ren;
      if (w_ren) begin
        r_rbin      <= w_rbin_nxt;
        r_rptr_gray <= w_rgray_ext[PTR_W-1:0];
      end
      if (w_err_cond) begin
        r_err <= 1'b1;
      end
    end
  end

  // RAM data lands the cycle after ren and is pushed at that edge.
  rd_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk  (clk),
    .rst  (rst),
    .push (r_inflight),
    .pop  (w_pop),
    .din  (rdata_mem),
    .dout (m_data),
    .cnt  (w_buf_cnt)
  );

  assign m_valid      = (w_buf_cnt != 2'd0);
  assign ren          = w_ren;
  assign raddr        = r_rbin[ADDR_W-1:0];
  assign rptr_gray    = r_rptr_gray;
  assign err          = r_err;
  assign empty        = (w_rd_count == '0) && (w_buf_cnt == 2'd0) && !r_inflight;
  assign almost_empty = (w_total <= TOT_W'(AE_THRESH));

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed bench for async_fifo_rd_ctrl: per-cycle vector table plus hand-written
// stream, backpressure, wrap, error and mid-burst reset sequences.
module tb_async_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] wptr = 4'd0;
  logic [3:0] rptr;
  logic       ren;
  logic [2:0] raddr;
  logic [7:0] rdata_mem = 8'd0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       empty;
  logic       ae;
  logic       err;

  int n_vec = 0;
  int n_err = 0;

  async_fifo_rd_ctrl #(
    .ADDR_W    (3),
    .DATA_W    (8),
    .AE_THRESH (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wptr_gray_sync (wptr),
    .rptr_gray      (rptr),
    .ren            (ren),
    .raddr          (raddr),
    .rdata_mem      (rdata_mem),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .empty          (empty),
    .almost_empty   (ae),
    .err            (err)
  );

  always #5 clk = ~clk;

  // RAM content at address a: A5 with the address in the upper nibble flipped.
  function automatic logic [7:0] word(input int k);
    logic [7:0] t;
    t = 8'(k & 7);
    return 8'hA5 ^ {t[3:0], 4'h0};
  endfunction

  function automatic logic [3:0] g(input int x);
    logic [3:0] b;
    b = 4'(x & 15);
    return b ^ (b >> 1);
  endfunction

  // Registered-output RAM stub
  always @(posedge clk) begin
    if (ren) rdata_mem <= word(int'(raddr));
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] wptr;
    logic       rdy;
    logic       ren;
    logic [2:0] raddr;
    logic [3:0] rptr;
    logic       mval;
    logic [7:0] mdata;
    logic       empty;
    logic       ae;
    logic       err;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; wptr = 4'd0; m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_stream(input string nm, input int base, input logic [3:0] wp);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      wptr = wp; m_ready = 1'b1;
      #1;
      chk({nm, ".ren"}, int'(ren), int'(c < 8));
      if (c < 8) chk({nm, ".raddr"}, int'(raddr), (base + c) & 7);
      chk({nm, ".rptr"}, int'(rptr), int'(g(base + ((c < 8) ? c : 8))));
      chk({nm, ".mval"}, int'(m_valid), int'(c >= 2 && c < 10));
      if (c >= 2 && c < 10) chk({nm, ".mdata"}, int'(m_data), int'(word(c - 2)));
      chk({nm, ".empty"}, int'(empty), int'(c >= 10));
      chk({nm, ".ae"}, int'(ae), int'(c >= 9));
    end
  endtask

  initial begin
    int npop;
    int nren;

    //            rst   wptr   rdy | ren  raddr rptr  mval mdata  empty ae   err
    tbl[0]  = '{1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 4'h1, 1'b0, 1'b1, 3'd0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 4'h1, 1'b0, 1'b0, 3'd1, 4'h1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 4'h1, 1'b0, 1'b0, 3'd1, 4'h1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'h1, 1'b1, 1'b0, 3'd1, 4'h1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'h1, 1'b1, 1'b0, 3'd1, 4'h1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 4'h2, 1'b0, 1'b1, 3'd1, 4'h1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'h2, 1'b0, 1'b1, 3'd2, 4'h3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'h2, 1'b0, 1'b0, 3'd3, 4'h2, 1'b1, 8'hB5, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'h2, 1'b0, 1'b0, 3'd3, 4'h2, 1'b1, 8'hB5, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'h2, 1'b1, 1'b0, 3'd3, 4'h2, 1'b1, 8'hB5, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'h2, 1'b1, 1'b0, 3'd3, 4'h2, 1'b1, 8'h85, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 4'h2, 1'b0, 1'b0, 3'd3, 4'h2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; wptr = tbl[i].wptr; m_ready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d.ren", i), int'(ren), int'(tbl[i].ren));
      chk($sformatf("v%0d.raddr", i), int'(raddr), int'(tbl[i].raddr));
      chk($sformatf("v%0d.rptr", i), int'(rptr), int'(tbl[i].rptr));
      chk($sformatf("v%0d.mval", i), int'(m_valid), int'(tbl[i].mval));
      if (tbl[i].mval) chk($sformatf("v%0d.mdata", i), int'(m_data), int'(tbl[i].mdata));
      chk($sformatf("v%0d.empty", i), int'(empty), int'(tbl[i].empty));
      chk($sformatf("v%0d.ae", i), int'(ae), int'(tbl[i].ae));
      chk($sformatf("v%0d.err", i), int'(err), int'(tbl[i].err));
    end

    // Eight-word stream, then wrap of the pointer through 15 -> 0
    do_reset;
    run_stream("stream", 0, 4'b1100);
    run_stream("wrap", 8, 4'b0000);

    // Backpressure: only two reads issue while the consumer stalls
    do_reset;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      wptr = 4'b1100; m_ready = 1'b0;
      #1;
      chk("bp.ren", int'(ren), int'(c < 2));
      if (c < 2) chk("bp.raddr", int'(raddr), c);
      chk("bp.mval", int'(m_valid), int'(c >= 2));
      if (c >= 2) chk("bp.hold", int'(m_data), int'(word(0)));
    end
    npop = 0;
    nren = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      if (ren) nren++;
      if (m_valid) begin
        chk("bp.order", int'(m_data), int'(word(npop)));
        npop++;
      end
    end
    chk("bp.count", npop, 8);
    chk("bp.rens", nren, 6);
    chk("bp.empty", int'(empty), 1);

    // Occupancy above depth: sticky error, no reads
    do_reset;
    @(negedge clk);
    wptr = 4'b1101; m_ready = 1'b0;
    #1;
    chk("err.ren0", int'(ren), 0);
    chk("err.pre", int'(err), 0);
    @(negedge clk);
    #1;
    chk("err.set", int'(err), 1);
    chk("err.ren1", int'(ren), 0);
    chk("err.mval", int'(m_valid), 0);
    chk("err.rptr", int'(rptr), 0);
    @(negedge clk);
    rst = 1'b1; wptr = 4'd0;
    #1;
    chk("err.clr", int'(err), 0);
    chk("err.rst_empty", int'(empty), 1);
    chk("err.rst_ae", int'(ae), 1);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-burst with a word in flight and one buffered
    @(negedge clk);
    wptr = 4'b1100; m_ready = 1'b0;
    #1;
    chk("mid.ren", int'(ren), 1);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1; wptr = 4'd0;
    #1;
    chk("mid.ren", int'(ren), 0);
    chk("mid.mval", int'(m_valid), 0);
    chk("mid.rptr", int'(rptr), 0);
    chk("mid.raddr", int'(raddr), 0);
    chk("mid.empty", int'(empty), 1);
    chk("mid.ae", int'(ae), 1);
    chk("mid.err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;
    run_stream("post", 0, 4'b1100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
